// File: rtl/led_pattern_if.sv
// LED pattern generator bus: step/mode/hold controls in, LED drive and wrap pulse out.
// With LED_PATTERN_PWM_EN defined the bus also carries the PWM duty setting.
interface led_pattern_if;
   logic       en;
   logic [1:0] mode;
   logic       hold;
   logic [7:0] led;
   logic       wrap;
`ifdef LED_PATTERN_PWM_EN
   logic [3:0] duty;

   modport master (output en, output mode, output hold, output duty,
                   input led, input wrap);
   modport slave  (input en, input mode, input hold, input duty,
                   output led, output wrap);
`else
   modport master (output en, output mode, output hold,
                   input led, input wrap);
   modport slave  (input en, input mode, input hold,
                   output led, output wrap);
`endif
endinterface

// File: rtl/led_pattern.sv
// LED pattern generator: binary count, rotate, ping-pong and blink patterns,
// advanced one step per en tick unless hold is set.
// Optional macro LED_PATTERN_PWM_EN adds a 4-bit duty input that dims the
// LED drive with a free-running 16-step PWM counter.
//
// Ping-pong state | meaning
// ----------------+---------------------------------------------
// PP_LEFT         | lit bit walking toward bit 7
// PP_RIGHT        | lit bit walking back toward bit 0
module led_pattern #(
   parameter logic [7:0] BLINK_MASK = 8'hFF
) (
   input  logic         clk,
   input  logic         rst,
   led_pattern_if.slave bus
);

   typedef enum logic {PP_LEFT, PP_RIGHT} pp_state_t;

   localparam logic [1:0] MODE_COUNT  = 2'd0;
   localparam logic [1:0] MODE_ROTATE = 2'd1;
   localparam logic [1:0] MODE_PING   = 2'd2;
   localparam logic [1:0] MODE_BLINK  = 2'd3;

   logic [7:0] r_pat;
   logic [1:0] r_mode_q;
   pp_state_t  r_pp;
   logic       r_wrap;
   logic [7:0] r_led;

   logic [7:0] w_pat_nxt;
   logic [1:0] w_mode_nxt;
   pp_state_t  w_pp_nxt;
   logic       w_wrap_nxt;
   logic [7:0] w_led_nxt;
   logic       w_step;
   logic       w_onehot;

   assign w_step   = bus.en & ~bus.hold;
   assign w_onehot = (r_pat != 8'h00) && ((r_pat & (r_pat - 8'd1)) == 8'h00);

   // State register: pattern, latched mode, ping-pong direction, outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pat    <= 8'h00;
         r_mode_q <= MODE_COUNT;
         r_pp     <= PP_LEFT;
         r_wrap   <= 1'b0;
         r_led    <= 8'h00;
      end else begin
         r_pat    <= w_pat_nxt;
         r_mode_q <= w_mode_nxt;
         r_pp     <= w_pp_nxt;
         r_wrap   <= w_wrap_nxt;
         r_led    <= w_led_nxt;
      end
   end

   // Next-state logic: a mode change only loads the start pattern; otherwise
   // the latched mode decides how the pattern advances and when it wraps.
   always_comb begin
      w_pat_nxt  = r_pat;
      w_mode_nxt = r_mode_q;
      w_pp_nxt   = r_pp;
      w_wrap_nxt = 1'b0;
      if (w_step) begin
         if (bus.mode != r_mode_q) begin
            w_mode_nxt = bus.mode;
            w_pp_nxt   = PP_LEFT;
            case (bus.mode)
               MODE_COUNT:  w_pat_nxt = 8'h00;
               MODE_ROTATE: w_pat_nxt = 8'h01;
               MODE_PING:   w_pat_nxt = 8'h01;
               default:     w_pat_nxt = 8'h00;
            endcase
         end else begin
            case (r_mode_q)
               MODE_COUNT: begin
                  w_pat_nxt  = r_pat + 8'd1;
                  w_wrap_nxt = (r_pat == 8'hFF);
               end
               MODE_ROTATE: begin
                  w_pat_nxt  = {r_pat[6:0], r_pat[7]};
                  w_wrap_nxt = (r_pat == 8'h80);
               end
               MODE_PING: begin
                  // Any corrupted or end-of-travel pattern restarts the walk.
                  if (!w_onehot) begin
                     w_pat_nxt = 8'h01;
                     w_pp_nxt  = PP_LEFT;
                  end else if (r_pp == PP_LEFT) begin
                     if (r_pat == 8'h80) begin
                        w_pat_nxt = 8'h01;
                        w_pp_nxt  = PP_LEFT;
                     end else if (r_pat == 8'h40) begin
                        w_pat_nxt = 8'h80;
                        w_pp_nxt  = PP_RIGHT;
                     end else begin
                        w_pat_nxt = r_pat << 1;
                     end
                  end else begin
                     if (r_pat == 8'h01) begin
                        w_pat_nxt = 8'h01;
                        w_pp_nxt  = PP_LEFT;
                     end else if (r_pat == 8'h02) begin
                        w_pat_nxt  = 8'h01;
                        w_pp_nxt   = PP_LEFT;
                        w_wrap_nxt = 1'b1;
                     end else begin
                        w_pat_nxt = r_pat >> 1;
                     end
                  end
               end
               default: begin
                  if (r_pat == BLINK_MASK) begin
                     w_pat_nxt  = 8'h00;
                     w_wrap_nxt = 1'b1;
                  end else if (r_pat == 8'h00) begin
                     w_pat_nxt = BLINK_MASK;
                  end else begin
                     w_pat_nxt = 8'h00;
                  end
               end
            endcase
         end
      end
   end

`ifdef LED_PATTERN_PWM_EN
   logic [3:0] r_pwm_cnt;
   logic [3:0] w_pwm_nxt;

   assign w_pwm_nxt = r_pwm_cnt + 4'd1;

   // Free-running PWM phase counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pwm_cnt <= 4'h0;
      end else begin
         r_pwm_cnt <= w_pwm_nxt;
      end
   end

   // LED is registered, so gate against the phase the counter will hold next.
   always_comb begin
      w_led_nxt = 8'h00;
      if ((bus.duty == 4'hF) || (w_pwm_nxt < bus.duty)) begin
         w_led_nxt = w_pat_nxt;
      end
   end
`else
   assign w_led_nxt = w_pat_nxt;
`endif

   assign bus.led  = r_led;
   assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern.sv
// Scoreboard bench for led_pattern (BLINK_MASK = 8'h0F). The driver pushes the
// expected led/wrap for the cycle after each stimulus vector; the monitor pops
// and compares on the falling edge of that cycle.
module tb_led_pattern;

   typedef struct {
      int         due;
      logic [7:0] led;
      logic       wrap;
      string      name;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_bad;
   exp_t sb[$];
   logic [7:0] pp_tab [15];

   led_pattern_if bus();

   led_pattern #(.BLINK_MASK(8'h0F)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [7:0] gl, input logic gw,
                      input logic [7:0] xl, input logic xw);
      n_cmp++;
      if (gl !== xl || gw !== xw) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got led=%h wrap=%b, expected led=%h wrap=%b",
                  nm, cyc, gl, gw, xl, xw);
      end
   endtask

   // Monitor: compare every expectation that has come due.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk(e.name, bus.led, bus.wrap, e.led, e.wrap);
      end
   end

   task automatic step(input logic e, input logic [1:0] m, input logic h,
                       input logic [7:0] xl, input logic xw, input string nm);
      exp_t x;
      bus.en   = e;
      bus.mode = m;
      bus.hold = h;
      x.due  = cyc + 1;
      x.led  = xl;
      x.wrap = xw;
      x.name = nm;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
         sb.delete();
      end
   endtask

`ifdef LED_PATTERN_PWM_EN
   task automatic pwm_check();
      int hits;
      drain();
      bus.en   = 1'b0;
      bus.duty = 4'd4;
      @(posedge clk);
      #1;
      hits = 0;
      repeat (32) begin
         @(negedge clk);
         if (bus.led == 8'hFF) hits++;
      end
      n_cmp++;
      if (hits != 8) begin
         n_bad++;
         $display("FAIL pwm_duty4: got %0d lit cycles of 32, expected 8", hits);
      end
      bus.duty = 4'hF;
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
      cyc   = 0;
      n_cmp = 0;
      n_bad = 0;
      rst      = 1'b0;
      bus.en   = 1'b0;
      bus.mode = 2'd0;
      bus.hold = 1'b0;
`ifdef LED_PATTERN_PWM_EN
      bus.duty = 4'hF;
`endif
      #12;
      chk("reset", bus.led, bus.wrap, 8'h00, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Binary count through a full cycle, wrap on FF->00 only.
      for (int i = 1; i <= 256; i++) begin
         step(1'b1, 2'd0, 1'b0, 8'(i), (i == 256), "count");
`ifdef LED_PATTERN_PWM_EN
         if (i == 255) pwm_check();
`endif
      end
      step(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, "count_idle");

      // Ping-pong: load, walk out and back, wrap on 02->01.
      for (int i = 0; i < 15; i++)
         step(1'b1, 2'd2, 1'b0, pp_tab[i], (i == 14), "pingpong");
      step(1'b1, 2'd2, 1'b0, 8'h02, 1'b0, "pingpong_restart");

      // Rotate: load 01, walk to 80, wrap back to 01.
      step(1'b1, 2'd1, 1'b0, 8'h01, 1'b0, "rotate_load");
      for (int i = 1; i < 8; i++)
         step(1'b1, 2'd1, 1'b0, 8'(1 << i), 1'b0, "rotate");
      step(1'b1, 2'd1, 1'b0, 8'h01, 1'b1, "rotate_wrap");
      step(1'b0, 2'd1, 1'b0, 8'h01, 1'b0, "rotate_idle");
      step(1'b1, 2'd1, 1'b1, 8'h01, 1'b0, "rotate_hold");

      // Mode change under hold waits for the first real step.
      step(1'b1, 2'd3, 1'b1, 8'h01, 1'b0, "hold_mode");
      step(1'b1, 2'd3, 1'b1, 8'h01, 1'b0, "hold_mode");
      step(1'b1, 2'd3, 1'b0, 8'h00, 1'b0, "blink_load");
      step(1'b1, 2'd3, 1'b0, 8'h0F, 1'b0, "blink");
      step(1'b1, 2'd3, 1'b0, 8'h00, 1'b1, "blink_wrap");
      step(1'b1, 2'd3, 1'b0, 8'h0F, 1'b0, "blink");
      step(1'b1, 2'd3, 1'b0, 8'h00, 1'b1, "blink_wrap");

      // Count to 37, then reset with a step pending.
      step(1'b1, 2'd0, 1'b0, 8'h00, 1'b0, "count_load");
      for (int i = 1; i <= 8'h37; i++)
         step(1'b1, 2'd0, 1'b0, 8'(i), 1'b0, "count37");
      drain();
      bus.en   = 1'b1;
      bus.mode = 2'd0;
      #2;
      rst = 1'b0;
      #1;
      chk("rst_async", bus.led, bus.wrap, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_held", bus.led, bus.wrap, 8'h00, 1'b0);
      rst    = 1'b1;
      bus.en = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 2'd0, 1'b0, 8'h01, 1'b0, "post_rst_count");
      step(1'b1, 2'd3, 1'b0, 8'h00, 1'b0, "post_rst_blink_load");
      step(1'b1, 2'd3, 1'b0, 8'h0F, 1'b0, "post_rst_blink");
      step(1'b0, 2'd3, 1'b0, 8'h0F, 1'b0, "final_idle");
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_pattern.md
LED_PATTERN -- requirements
Module: led_pattern

Interface
REQ-001 Parameter: BLINK_MASK, 8'hFF, LED set driven in blink mode.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 Port: en  input  1  single-cycle step tick from the upstream clock divider; one pattern step per tick.
REQ-005 Port: mode  input  2  pattern select: 0 binary count, 1 rotate, 2 ping-pong, 3 blink.
REQ-006 Port: hold  input  1  1 = freeze the pattern; en ticks are ignored.
REQ-007 Port: led  output  8  registered LED drive.
REQ-008 Port: wrap  output  1  one-cycle pulse when a pattern completes a full cycle.

Function
REQ-009 The block SHALL keep internal state: pattern register pat[7:0], latched mode mode_q[1:0], ping-pong FSM state {LEFT, RIGHT}.
REQ-010 The block SHALL sample mode and act only in cycles where en=1 and hold=0 ("step cycle"); it SHALL leave all state unchanged in all other cycles.
REQ-011 On a step cycle with mode != mode_q, the block SHALL load mode_q<=mode and the initial pattern: mode0 8'h00, mode1 8'h01, mode2 8'h01 with FSM=LEFT, mode3 8'h00. It SHALL NOT assert wrap and SHALL NOT advance.
REQ-012 Mode0 step: pat <= pat+1 modulo 256; wrap when old pat = 8'hFF.
REQ-013 Mode1 step: pat rotates left one bit (bit7 -> bit0); wrap when old pat = 8'h80.
REQ-014 Mode2 LEFT step: pat <= pat<<1; when old pat = 8'h40, pat <= 8'h80 and FSM -> RIGHT.
REQ-015 Mode2 RIGHT step: pat <= pat>>1; when old pat = 8'h02, pat <= 8'h01, FSM -> LEFT, and wrap asserts.
REQ-016 Mode2 with non-one-hot pat, or with pat = 8'h80 in LEFT or 8'h01 in RIGHT: the next step SHALL load 8'h01, FSM=LEFT, with no wrap.
REQ-017 Mode3 step: pat toggles between 8'h00 and BLINK_MASK; wrap when old pat = BLINK_MASK. Any other value SHALL load 8'h00.
REQ-018 wrap SHALL be high for exactly the clk cycle after the step cycle that caused it, and low otherwise.
REQ-019 led SHALL equal pat, registered, and update in the cycle after the step cycle (latency 1).
REQ-020 en held high for consecutive cycles SHALL produce one step per cycle.
REQ-021 A mode change while hold=1 SHALL take effect at the first step cycle after hold falls.

Reset
REQ-022 While rst=0, asynchronously: pat=8'h00, mode_q=0, FSM=LEFT, led=8'h00, wrap=0.
REQ-023 Reset asserted mid-pattern SHALL discard the current step. After release, the first step cycle SHALL follow REQ-011/REQ-012 against mode_q=0.

Configuration
REQ-024 Macro LED_PATTERN_PWM_EN defined: the block SHALL add input duty[3:0] and a free-running 4-bit counter pwm_cnt (reset 0, increments every clk). It SHALL drive led = pat when pwm_cnt < duty, or when duty = 4'hF; otherwise led = 8'h00 (duty 0 = dark).
REQ-025 LED_PATTERN_PWM_EN undefined: the block SHALL have no duty port and no pwm_cnt, and led SHALL follow REQ-019.

Verification
REQ-026 Reset, mode=0, 256 en ticks with hold=0: led = 00,01,...,FF,00. wrap pulses once, on the FF->00 step.
REQ-027 mode=2 from reset: first tick loads 01, then 02,04,...,80,40,...,01. FSM turns at 80, and wrap pulses on 02->01 only.
REQ-028 mode=1 at pat=80, tick: led=01 and wrap=1 for one cycle. Tick with hold=1: led stays unchanged and wrap=0.
REQ-029 mode=3 with BLINK_MASK=8'h0F, 4 ticks after the mode load: led = 0F,00,0F,00. wrap pulses on each 0F->00 step.
REQ-030 rst pulsed low mid-count at pat=37: led=00 immediately, and no wrap. LED_PATTERN_PWM_EN with duty=4, pat=FF: led=FF for 4 of every 16 clks.
